// File: rtl/fpm_pkg.sv
// fpm_pkg
// Shared constants for the floating-point multiplier stream controller:
// IEEE-754 single-precision field positions, result flag indices, the
// controller state encoding and small field-extraction helpers.
// No ports (package).

package fpm_pkg;

  // IEEE-754 single-precision field layout
  localparam int         SIGN_BIT = 31;
  localparam int         EXP_MSB  = 30;
  localparam int         EXP_LSB  = 23;
  localparam int         MANT_W   = 23;
  localparam logic [7:0] EXP_ONES = 8'hFF;

  // Result flag bit positions within a 4-bit flag vector
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;
  localparam int FLAGS_W   = 4;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_B = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Packed view of the flags; member order matches the FLAG_* indices.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic ovf;
  } fp_flags_t;

  function automatic logic [7:0] fp_exp(input logic [31:0] word);
    return word[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [MANT_W-1:0] fp_mant(input logic [31:0] word);
    return word[MANT_W-1:0];
  endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify
// Combinational classification of a single-precision product word.
// Sign is ignored; denormals are reported as zero.
// Ports:
//   word_i  [31:0] product word
//   ovf_i          multiplier overflow, passed through as the ovf flag
//   flags_o [3:0]  {nan, inf, zero, ovf}

module fp_classify
  import fpm_pkg::*;
(
  input  logic [31:0]        word_i,
  input  logic               ovf_i,
  output logic [FLAGS_W-1:0] flags_o
);

  logic [7:0]        exp_w;
  logic [MANT_W-1:0] mant_w;
  logic              exp_all_ones;
  logic              mant_nonzero;
  fp_flags_t         flags;
  logic              unused_sign;

  assign exp_w        = fp_exp(word_i);
  assign mant_w       = fp_mant(word_i);
  assign exp_all_ones = (exp_w == EXP_ONES);
  assign mant_nonzero = |mant_w;

  // Sign does not participate in any flag.
  assign unused_sign = word_i[SIGN_BIT];

  always_comb begin
    flags      = '0;
    flags.nan  = exp_all_ones &  mant_nonzero;
    flags.inf  = exp_all_ones & ~mant_nonzero;
    flags.zero = (exp_w == 8'h00);
    flags.ovf  = ovf_i;
  end

  assign flags_o = flags;

endmodule

// File: rtl/fpm_stream_ctrl.sv
// fpm_stream_ctrl
// Stream controller in front of a combinational FP multiplier. Consecutive
// accepted input words form an operand pair (a, b); after MUL_LATENCY cycles
// the product and overflow are captured, classified and held as a
// valid/ready result until downstream takes it.
//
// Optional feature macro: FPM_STATUS_STICKY_EN
//   defined   : status accumulates out_flags of every output handshake,
//               status_clr clears it (clear applied before the OR).
//   undefined : status is constant 0, status_clr is ignored.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand word handshake, in_data [31:0]
//   mul_a/mul_b [31:0]    registered operands to the multiplier
//   mul_product [31:0]    multiplier result, mul_overflow its overflow flag
//   out_valid/out_ready   result handshake, out_data [31:0], out_flags [3:0]
//   status_clr            clear sticky status
//   status [3:0]          sticky flags {nan, inf, zero, ovf}
//
// State table:
//   state   | meaning
//   IDLE    | waiting for operand a
//   WAIT_B  | a registered, waiting for operand b
//   MUL     | operands stable on multiplier, settle counter running
//   HOLD    | result captured, out_valid high until out_ready

module fpm_stream_ctrl
  import fpm_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [31:0]        mul_product,
  input  logic               mul_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [FLAGS_W-1:0] out_flags,
  input  logic               status_clr,
  output logic [FLAGS_W-1:0] status
);

  // Counter reaches 0 after MUL_LATENCY-1 decrements, so the capture edge
  // is exactly MUL_LATENCY edges after the b handshake.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [FLAGS_W-1:0] out_flags_q, out_flags_d;
  logic [FLAGS_W-1:0] cls_flags;
  logic               out_hs;

  fp_classify u_classify (
    .word_i  (mul_product),
    .ovf_i   (mul_overflow),
    .flags_o (cls_flags)
  );

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT_B);
  assign out_valid = (state_q == ST_HOLD);
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mul_a_d = in_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (in_valid) begin
          mul_b_d = in_data;
          cnt_d   = CNT_LOAD;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (cnt_q == 4'd0) begin
          out_data_d  = mul_product;
          out_flags_d = cls_flags;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

`ifdef FPM_STATUS_STICKY_EN
  logic [FLAGS_W-1:0] status_q, status_d;

  // Clear first, then OR, so a clear coinciding with a handshake keeps
  // that handshake's flags.
  always_comb begin
    status_d = status_clr ? '0 : status_q;
    if (out_hs) begin
      status_d = status_d | out_flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;
`else
  logic unused_status_clr;
  logic unused_out_hs;

  assign unused_status_clr = status_clr;
  assign unused_out_hs     = out_hs;
  assign status            = '0;
`endif

endmodule

// File: tb/tb_fpm_stream_ctrl.sv
module tb_fpm_stream_ctrl;

  localparam logic [31:0] BP_WORD = 32'h1234_5678;

`ifdef FPM_STATUS_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid     [2];
  logic        in_ready     [2];
  logic [31:0] in_data      [2];
  logic [31:0] mul_a        [2];
  logic [31:0] mul_b        [2];
  logic [31:0] mul_product  [2];
  logic        mul_overflow [2];
  logic        out_valid    [2];
  logic        out_ready    [2];
  logic [31:0] out_data     [2];
  logic [3:0]  out_flags    [2];
  logic        status_clr   [2];
  logic [3:0]  status       [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fpm_stream_ctrl #(.MUL_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_product(mul_product[0]), .mul_overflow(mul_overflow[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_flags(out_flags[0]),
    .status_clr(status_clr[0]), .status(status[0])
  );

  fpm_stream_ctrl #(.MUL_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_product(mul_product[1]), .mul_overflow(mul_overflow[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_flags(out_flags[1]),
    .status_clr(status_clr[1]), .status(status[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Flags from plain field arithmetic on the product word.
  function automatic logic [3:0] classify(input logic [31:0] w, input logic o);
    int unsigned e;
    int unsigned m;
    e = (w >> 23) & 32'hFF;
    m = w & 32'h7F_FFFF;
    return {(e == 255) && (m != 0), (e == 255) && (m == 0), (e == 0), o};
  endfunction

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Transaction-level reference: counts pending operands, cycles since b,
  // and whether a result is waiting to be taken.
  logic        m_have_a [2];
  int          m_since  [2];
  logic        m_res_v  [2];
  logic [31:0] m_a      [2];
  logic [31:0] m_b      [2];
  logic [31:0] m_res_d  [2];
  logic [3:0]  m_res_f  [2];
  logic [3:0]  m_st     [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_have_a[k] = 0; m_since[k] = -1; m_res_v[k] = 0;
        m_a[k] = 0; m_b[k] = 0; m_res_d[k] = 0; m_res_f[k] = 0; m_st[k] = 0;
      end else begin
        logic rdy;
        logic hs;
        rdy = !((m_since[k] >= 0) || m_res_v[k]);
        hs  = m_res_v[k] && out_ready[k];
        if (STICKY) begin
          if (status_clr[k]) m_st[k] = 0;
          if (hs) m_st[k] = m_st[k] | m_res_f[k];
        end
        if (hs) m_res_v[k] = 0;
        if (m_since[k] >= 0) begin
          m_since[k]++;
          if (m_since[k] == lat_of(k)) begin
            m_res_d[k] = mul_product[k];
            m_res_f[k] = classify(mul_product[k], mul_overflow[k]);
            m_res_v[k] = 1;
            m_since[k] = -1;
          end
        end
        if (rdy && in_valid[k]) begin
          if (!m_have_a[k]) begin
            m_a[k] = in_data[k];
            m_have_a[k] = 1;
          end else begin
            m_b[k] = in_data[k];
            m_have_a[k] = 0;
            m_since[k] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, in_ready[k], !((m_since[k] >= 0) || m_res_v[k]));
        check("out_valid", k, out_valid[k], m_res_v[k]);
        check("mul_a", k, mul_a[k], m_a[k]);
        check("mul_b", k, mul_b[k], m_b[k]);
        check("out_data", k, out_data[k], m_res_d[k]);
        check("out_flags", k, out_flags[k], m_res_f[k]);
        check("status", k, status[k], m_st[k]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input int k, input logic [31:0] w);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", k, (n >= 50), 0);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (!out_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", k, out_valid[k], 1);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  task automatic run_pair(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prod, input logic ovf,
                          input logic [3:0] exp_flags, input int hold, input bit clr);
    int n;
    mul_product[k]  = prod;
    mul_overflow[k] = ovf;
    out_ready[k]    = 1'b0;
    send_word(k, a);
    send_word(k, b);
    n = 0;
    while (!out_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("result_latency", k, n, lat_of(k));
    check("lit_out_data", k, out_data[k], prod);
    check("lit_out_flags", k, out_flags[k], exp_flags);
    if (hold > 0) begin
      in_valid[k] = 1'b1;
      in_data[k]  = BP_WORD;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", k, out_valid[k], 1);
      check("hold_in_ready", k, in_ready[k], 0);
      check("hold_out_data", k, out_data[k], prod);
      check("hold_mul_a", k, mul_a[k], a);
    end
    out_ready[k]  = 1'b1;
    status_clr[k] = clr;
    @(negedge clk);
    out_ready[k]  = 1'b0;
    status_clr[k] = 1'b0;
    check("post_hs_out_valid", k, out_valid[k], 0);
    check("post_hs_in_ready", k, in_ready[k], 1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = {r[31], 8'hFF, 23'h0};
      1: r = {r[31], 8'hFF, r[22:1], 1'b1};
      2: r = {r[31], 8'h00, r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; in_data[k] = 0; mul_product[k] = 0; mul_overflow[k] = 0;
      out_ready[k] = 0; status_clr[k] = 0;
    end
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 0, in_ready[0], 1);
    check("rst_out_valid", 0, out_valid[0], 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_pair(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 4'b0000, 0, 0);
    run_pair(0, 32'hC243_B852, 32'h0000_0000, 32'h8000_0000, 1'b0, 4'b0010, 0, 0);
    run_pair(0, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 4'b0100, 0, 0);
    run_pair(0, 32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 1'b0, 4'b1000, 0, 0);
    run_pair(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 4'b0101, 0, 0);

    // Backpressure with a stream word waiting; it must be taken as the next a.
    run_pair(0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'b0000, 5, 0);
    send_word(0, BP_WORD);
    check("bp_word_as_a", 0, mul_a[0], BP_WORD);
    send_word(0, 32'h4000_0000);
    drain(0);

    run_pair(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 4'b0000, 0, 0);

    // Reset during MUL (latency 3).
    mul_product[1] = 32'h4110_0000;
    send_word(1, 32'h4040_0000);
    send_word(1, 32'h4040_0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 1, in_ready[1], 1);
    check("rst_mid_out_valid", 1, out_valid[1], 0);
    check("rst_mid_mul_a", 1, mul_a[1], 0);
    check("rst_mid_mul_b", 1, mul_b[1], 0);
    check("rst_mid_out_data", 1, out_data[1], 0);
    check("rst_mid_out_flags", 1, out_flags[1], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_pair(1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 4'b0000, 0, 0);

    // Sticky status on the latency-1 instance.
    status_clr[0] = 1'b1;
    @(negedge clk);
    status_clr[0] = 1'b0;
    check("status_after_clr", 0, status[0], 0);
    run_pair(0, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 4'b0100, 0, 0);
    run_pair(0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0010, 0, 0);
    check("status_inf_zero", 0, status[0], STICKY ? 4'b0110 : 4'b0000);
    run_pair(0, 32'h7FC0_0000, 32'h4000_0000, 32'h7FC0_0000, 1'b0, 4'b1000, 0, 1);
    check("status_clr_nan", 0, status[0], STICKY ? 4'b1000 : 4'b0000);

    // Randomized traffic on both instances, checked by the model each cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        in_valid[k]     = ($urandom_range(0, 1) == 1);
        in_data[k]      = rand_word();
        out_ready[k]    = ($urandom_range(0, 2) != 0);
        mul_product[k]  = rand_word();
        mul_overflow[k] = ($urandom_range(0, 7) == 0);
        status_clr[k]   = ($urandom_range(0, 15) == 0);
      end
      if (c == 700) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; out_ready[k] = 1; status_clr[k] = 0;
    end
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
